seq_stream_arbiter: RTL
=======================

Name: seq_stream_arbiter

Overview:
- Round-robin scheduler that shares one bit-serial sequence-detector FSM among NUM_REQ word requesters.
- Accepts one DATA_W-bit word at a time and pulses a clear to the shared FSM.
- Serialises the word LSB-first over a valid/ready bit stream, then reports completion with the granted requester index.
- Sits between the word-level producers and the shared serial detector.

Parameters:
- NUM_REQ, 4, number of requesters (>=2, need not be a power of 2).
- DATA_W, 8, word width in bits (>=2).
- IDX_W, 2, width of requester index; must satisfy 2^IDX_W >= NUM_REQ.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_data  in  NUM_REQ*DATA_W  packed words; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot accept strobe.
- fsm_clr  out  1  one-cycle synchronous clear to the shared FSM.
- ser_valid  out  1  serial bit valid.
- ser_bit  out  1  current serial bit.
- ser_last  out  1  marks bit DATA_W-1 of the word.
- ser_ready  in  1  downstream accepts the bit this cycle.
- done  out  1  one-cycle completion pulse.
- done_id  out  IDX_W  requester index of the completed word; held until the next done.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, rr_ptr=0, shreg=0, bit_cnt=0, grant_id=0, done_id=0.
  - All outputs low.
  - Takes effect immediately, even mid-word: ser_valid drops at once, no done is issued, and the word in flight is discarded.
- States: IDLE -> CLEAR -> SHIFT -> DONE -> IDLE.
- IDLE:
  - winner = first i with req_valid[i], searching i = rr_ptr, rr_ptr+1, ... with wrap-around modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in the same cycle. This is the only cycle any req_ready is high. All other req_ready bits are 0.
  - On that edge: shreg<=req_data[winner], grant_id<=winner, bit_cnt<=0, go to CLEAR.
  - No req_valid set: stay in IDLE, no outputs asserted.
- CLEAR:
  - fsm_clr=1 for exactly this one cycle; ser_valid=0.
  - Next state is SHIFT unconditionally.
- SHIFT:
  - ser_valid=1, ser_bit=shreg[0], ser_last=(bit_cnt==DATA_W-1).
  - On ser_ready=1: shreg shifts right one bit, bit_cnt increments. If ser_last, go to DONE.
  - On ser_ready=0: ser_bit, ser_last and bit_cnt hold (stall of any length).
- DONE:
  - done=1 and done_id<=grant_id, both for one cycle.
  - rr_ptr <= (grant_id==NUM_REQ-1) ? 0 : grant_id+1.
  - Next state is IDLE.
- Latency and throughput:
  - req accept to first ser_valid is 2 cycles.
  - Minimum word period is DATA_W+3 cycles with ser_ready held high.
- Request-line rules:
  - req_valid changes on non-granted lines during CLEAR/SHIFT/DONE are ignored.
  - A requester dropping req_valid before it is granted is never served.
  - The granted requester's req_data may change after the accept cycle without affecting the word in flight.
- Fairness: a continuously requesting line waits at most NUM_REQ-1 words.
- bit_cnt width is clog2(DATA_W); it never wraps inside a word.

Test Plan:
- Reset, all req_valid=0 for 10 cycles -> every output 0, busy=0.
- req_valid=4'b0001, data0=8'hA5, ser_ready=1:
  - req_ready=0001 in cycle 0 and fsm_clr in cycle 1.
  - ser_bit 1,0,1,0,0,1,0,1 in cycles 2-9, with ser_last in cycle 9.
  - done=1 with done_id=0 in cycle 10.
- req_valid=4'b1111 held for 4 words -> grants in order 0,1,2,3; 5th grant is 0; done_id sequence 0,1,2,3,0.
- ser_ready low for 3 cycles at bit 4 of word 8'h3C -> ser_bit stays 1 for those cycles; total word period 14 cycles; serial sequence still 0,0,1,1,1,1,0,0.
- reset_n pulsed low during bit 5 of a word from requester 2:
  - ser_valid falls without waiting for a clock edge; no done.
  - After release with req_valid=4'b0100, requester 2 is regranted and rr_ptr restarts from 0.
- rr_ptr=3 after a grant to requester 2, then req_valid=4'b0101 -> requester 0 granted, because the search wraps 3 -> 0.

Source files
------------

// File: rtl/seq_stream_arbiter.sv
// rtl/seq_stream_arbiter.sv - round-robin word arbiter feeding a shared bit-serial detector
module seq_stream_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int IDX_W   = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      fsm_clr,
    output logic                      ser_valid,
    output logic                      ser_bit,
    output logic                      ser_last,
    input  logic                      ser_ready,
    output logic                      done,
    output logic [IDX_W-1:0]          done_id,
    output logic                      busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   grant_id;
    logic [DATA_W-1:0]  shreg;
    logic [CNT_W-1:0]   bit_cnt;

    logic               found;
    logic [IDX_W-1:0]   winner;
    logic [DATA_W-1:0]  win_data;
    logic               last_bit;

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        int j;
        found    = 1'b0;
        winner   = '0;
        win_data = '0;
        j        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!found && req_valid[j]) begin
                found    = 1'b1;
                winner   = IDX_W'(j);
                win_data = req_data[j*DATA_W +: DATA_W];
            end
        end
    end

    // Accept strobe only exists in IDLE, and only for the search winner
    always_comb begin
        req_ready = '0;
        if (state == IDLE && found) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign last_bit  = (bit_cnt == CNT_W'(DATA_W - 1));
    assign fsm_clr   = (state == CLEAR);
    assign ser_valid = (state == SHIFT);
    assign ser_bit   = (state == SHIFT) & shreg[0];
    assign ser_last  = (state == SHIFT) & last_bit;
    assign done      = (state == DONE);
    assign busy      = (state != IDLE);

    // Scheduler FSM: grant, clear the detector, shift the word out, report completion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            shreg    <= '0;
            bit_cnt  <= '0;
            done_id  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        shreg    <= win_data;
                        grant_id <= winner;
                        bit_cnt  <= '0;
                        state    <= CLEAR;
                    end
                end
                CLEAR: begin
                    state <= SHIFT;
                end
                SHIFT: begin
                    if (ser_ready) begin
                        shreg <= shreg >> 1;
                        if (last_bit) begin
                            // done_id is loaded here so it is valid during the done cycle
                            done_id <= grant_id;
                            state   <= DONE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    rr_ptr <= (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
